// File: rtl/matrix_scan_gen.sv
// rtl/matrix_scan_gen.sv - column-major LED matrix scan generator with blanking and single-step
// Drives mdc/mdl for the downstream 1:4 demux selector; all outputs are registered.
module matrix_scan_gen #(
  parameter int PRESCALE = 4,
  parameter int N_COL    = 5,
  parameter int N_LIN    = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       step,
  output logic [2:0] mdc,
  output logic [2:0] mdl,
  output logic       blank,
  output logic       frame_done
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_RUN    = 2'd1;
  localparam logic [1:0]  S_BLANK  = 2'd2;
  localparam logic [15:0] TERM     = 16'(PRESCALE - 1);
  localparam logic [2:0]  LAST_COL = 3'(N_COL - 1);
  localparam logic [2:0]  LAST_LIN = 3'(N_LIN - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [2:0]  mdc_q, mdc_d;
  logic [2:0]  mdl_q, mdl_d;
  logic        blank_q, blank_d;
  logic        frame_done_q, frame_done_d;
  logic [2:0]  sync_q, sync_d;
  logic        step_edge;
  logic        advance;

  always_comb begin
    // bits [1:0] form the synchronizer, bit [2] is the edge-detect history
    sync_d    = {sync_q[1:0], step};
    step_edge = sync_q[1] & ~sync_q[2];

    state_d = state_q;
    presc_d = presc_q;
    advance = 1'b0;
    case (state_q)
      S_IDLE: begin
        presc_d = 16'd0;
        if (en) begin
          state_d = S_RUN;
        end else if (step_edge) begin
          advance = 1'b1;
          state_d = S_BLANK;
        end
      end
      S_RUN: begin
        // dropping en wins over a coinciding terminal count: position is held
        if (!en) begin
          state_d = S_IDLE;
          presc_d = 16'd0;
        end else if (presc_q == TERM) begin
          presc_d = 16'd0;
          advance = 1'b1;
          state_d = S_BLANK;
        end else begin
          presc_d = presc_q + 16'd1;
        end
      end
      S_BLANK: begin
        state_d = en ? S_RUN : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        presc_d = 16'd0;
      end
    endcase

    mdc_d        = mdc_q;
    mdl_d        = mdl_q;
    frame_done_d = 1'b0;
    if (advance) begin
      if (mdl_q < LAST_LIN) begin
        mdl_d = mdl_q + 3'd1;
      end else begin
        mdl_d = 3'd0;
        if (mdc_q < LAST_COL) begin
          mdc_d = mdc_q + 3'd1;
        end else begin
          mdc_d        = 3'd0;
          frame_done_d = 1'b1;
        end
      end
    end

    blank_d = (state_d != S_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      presc_q      <= 16'd0;
      mdc_q        <= 3'd0;
      mdl_q        <= 3'd0;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
      sync_q       <= 3'd0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      mdc_q        <= mdc_d;
      mdl_q        <= mdl_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
      sync_q       <= sync_d;
    end
  end

  assign mdc        = mdc_q;
  assign mdl        = mdl_q;
  assign blank      = blank_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/matrix_scan_gen.md
Name: matrix_scan_gen

Overview:
- Scan generator directly upstream of the 1:4 demux selector stage.
- Produces the column index mdc and line index mdl that the selector decodes into dmx4_sel.
- Walks a 5-column by 7-line LED matrix in column-major order at a prescaled rate.
- Provides blanking around each position change, a single-step mode and an end-of-frame pulse.

Parameters:
- PRESCALE, 4, clock cycles per scan position; legal range 2..65535.
- N_COL, 5, number of columns; legal range 1..8.
- N_LIN, 7, number of lines; legal range 1..8.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  run enable; 1 = free-running scan, 0 = paused / step mode.
- step  input  1  asynchronous single-step request; honoured only while en=0.
- mdc  output  3  current column index, 0..N_COL-1; feeds the selector.
- mdl  output  3  current line index, 0..N_LIN-1; feeds the selector.
- blank  output  1  1 = display drivers must be off this cycle.
- frame_done  output  1  one-cycle pulse when the scan wraps from the last position to 0,0.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - mdc=0, mdl=0, blank=1, frame_done=0.
  - Prescaler=0, FSM=IDLE, step synchronizer flops=0.
  - On release, the first state change occurs on the first rising clk edge with rst_n=1.
- FSM states: IDLE, RUN, BLANK.
- IDLE:
  - blank=1, prescaler held at 0.
  - en=1 -> RUN.
  - en=0 and a step edge detected -> advance the position, go to BLANK.
- RUN:
  - blank=0; prescaler increments every cycle.
  - When the prescaler reaches PRESCALE-1: prescaler=0, advance the position, go to BLANK.
  - en=0 in RUN -> IDLE next cycle, prescaler cleared, position held (no advance, even if the terminal count coincides).
- BLANK:
  - Lasts exactly 1 cycle with blank=1; the new mdc/mdl are already valid during it.
  - Exit to RUN if en=1, else IDLE.
- Advance rule:
  - If mdl < N_LIN-1: mdl+1.
  - Otherwise mdl=0 and, if mdc < N_COL-1, mdc+1.
  - Otherwise mdc=0 and frame_done=1 for the same single cycle in which the wrapped 0,0 first appears (the BLANK cycle).
- Position period in RUN: PRESCALE+1 cycles (PRESCALE counting, 1 blank). Frame = N_COL*N_LIN*(PRESCALE+1) cycles.
- Step input:
  - Two-flop synchronizer, then rising-edge detect.
  - The edge is consumed even when ignored (en=1), so there is no deferred step later.
  - A held-high step produces exactly one advance.
- mdc/mdl never leave their legal ranges; no intermediate illegal value is ever presented downstream.
- en toggled during BLANK: takes effect on the exit transition only.
- Reset mid-scan: immediate return to 0,0 with blank=1; any pending step edge is discarded.
- Outputs are registered; no combinational path from en or step to any output.

Test Plan:
- Reset, then en=1 with PRESCALE=4 -> mdl goes 0->1 after 5 cycles; blank is high only in the 1 cycle after each advance.
- en=1 for a full frame -> sequence (0,0),(0,1)..(0,6),(1,0)..(4,6),(0,0); frame_done high exactly once at cycle 175, coincident with the (0,0) blank cycle.
- en=0, three step pulses (one held high for 10 cycles) -> exactly three advances to mdl=3; held step gives one advance; en=1 pulses on step produce none.
- en dropped at prescaler count 3 (terminal) -> no advance, FSM to IDLE, blank=1, position held; en=1 again -> resumes with a full PRESCALE count.
- rst_n asserted asynchronously mid-cycle at position (3,5) -> outputs become 0,0 with blank=1 before the next clk edge; no frame_done.
- N_COL=1, N_LIN=1 -> every advance wraps; frame_done pulses every PRESCALE+1 cycles; mdc=mdl=0 throughout.
